// File: rtl/gfx_line_pixel_sink.sv
// Bresenham pixel-stream sink: maps major/minor to x/y, culls, queues writes.
// Ports: rasterizer side (busy_i, valid_i, x_major_i, major_i, minor_i,
// read_pixel_o, color_i), bounds (target_*, clip_*), write request side
// (write_o, x_o, y_o, color_o, ack_i) and status (busy_o, done_o,
// written_o, discarded_o). Optional macro GFX_LINE_CLIP_EN adds clip rect.
module gfx_line_pixel_sink #(
    parameter int point_width     = 16,
    parameter int fifo_depth_log2 = 2,
    parameter int color_width     = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          busy_i,
    input  logic                          valid_i,
    input  logic                          x_major_i,
    input  logic signed [point_width-1:0] major_i,
    input  logic signed [point_width-1:0] minor_i,
    output logic                          read_pixel_o,
    input  logic [color_width-1:0]        color_i,
    input  logic [point_width-1:0]        target_width_i,
    input  logic [point_width-1:0]        target_height_i,
    input  logic [point_width-1:0]        clip_x0_i,
    input  logic [point_width-1:0]        clip_y0_i,
    input  logic [point_width-1:0]        clip_x1_i,
    input  logic [point_width-1:0]        clip_y1_i,
    output logic                          write_o,
    output logic [point_width-1:0]        x_o,
    output logic [point_width-1:0]        y_o,
    output logic [color_width-1:0]        color_o,
    input  logic                          ack_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [31:0]                   written_o,
    output logic [31:0]                   discarded_o
);
    localparam int depth = 1 << fifo_depth_log2;
    localparam int cw    = fifo_depth_log2 + 1;
    localparam logic [fifo_depth_log2-1:0] ptr_one = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       pending_q;
    logic [color_width-1:0]     color_q;
    logic [point_width-1:0]     mem_x [depth];
    logic [point_width-1:0]     mem_y [depth];
    logic [fifo_depth_log2-1:0] wr_ptr_q, rd_ptr_q;
    logic [cw-1:0]              count_q;
    logic [31:0]                written_q, discarded_q;

    logic signed [point_width-1:0] px, py;
    logic [point_width-1:0]        ux, uy;
    logic in_screen, in_clip, visible;
    logic empty, full, pop, push, line_start;

    assign px = x_major_i ? major_i : minor_i;
    assign py = x_major_i ? minor_i : major_i;
    assign ux = $unsigned(px);
    assign uy = $unsigned(py);

    // Negative coords rejected via sign bit; the rest compare unsigned.
    assign in_screen = !px[point_width-1] && !py[point_width-1] &&
                       (ux < target_width_i) && (uy < target_height_i);

`ifdef GFX_LINE_CLIP_EN
    logic [point_width-1:0] cx0_q, cy0_q, cx1_q, cy1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cx0_q <= '0;
            cy0_q <= '0;
            cx1_q <= '0;
            cy1_q <= '0;
        end else if (line_start) begin
            cx0_q <= clip_x0_i;
            cy0_q <= clip_y0_i;
            cx1_q <= clip_x1_i;
            cy1_q <= clip_y1_i;
        end
    end

    assign in_clip = (ux >= cx0_q) && (ux < cx1_q) &&
                     (uy >= cy0_q) && (uy < cy1_q);
`else
    logic unused_clip;
    assign unused_clip = ^{clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i};
    assign in_clip     = 1'b1;
`endif

    assign visible    = in_screen && in_clip;
    assign empty      = (count_q == '0);
    assign full       = (count_q == cw'(depth));
    assign write_o    = !empty;
    assign pop        = write_o && ack_i;
    assign line_start = (state_q == IDLE) && busy_i;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign read_pixel_o = (state_q == RUN) && (valid_i || pending_q) &&
                          (!full || pop);
    assign push = read_pixel_o && visible;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_x[wr_ptr_q] <= ux;
            mem_y[wr_ptr_q] <= uy;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + ptr_one;
            if (pop)
                rd_ptr_q <= rd_ptr_q + ptr_one;
            count_q <= count_q + cw'(push) - cw'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            color_q     <= '0;
            written_q   <= '0;
            discarded_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != RUN || read_pixel_o)
                pending_q <= 1'b0;
            else if (valid_i)
                pending_q <= 1'b1;
            if (line_start) begin
                color_q     <= color_i;
                written_q   <= '0;
                discarded_q <= '0;
            end else if (read_pixel_o) begin
                if (visible) begin
                    if (written_q != '1)
                        written_q <= written_q + 32'd1;
                end else if (discarded_q != '1) begin
                    discarded_q <= discarded_q + 32'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (busy_i) state_d = RUN;
            RUN:   if (!busy_i && !pending_q && !valid_i) state_d = DRAIN;
            DRAIN: if (empty) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign x_o         = write_o ? mem_x[rd_ptr_q] : '0;
    assign y_o         = write_o ? mem_y[rd_ptr_q] : '0;
    assign color_o     = write_o ? color_q : '0;
    assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);
    assign written_o   = written_q;
    assign discarded_o = discarded_q;
endmodule

// File: tb/tb_gfx_line_pixel_sink.sv
// Directed bench for gfx_line_pixel_sink.
// Rasterizer driver, write monitor, immediate-assertion checks.
module tb_gfx_line_pixel_sink;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        busy_i, valid_i, x_major_i, read_pixel_o;
    logic signed [15:0] major_i, minor_i;
    logic [31:0] color_i;
    logic [15:0] target_width_i, target_height_i;
    logic [15:0] clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i;
    logic        write_o, ack_i, busy_o, done_o;
    logic [15:0] x_o, y_o;
    logic [31:0] color_o, written_o, discarded_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_ack = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int stalls = 0;
    int qx[$], qy[$], ex[$], ey[$];
    logic [31:0] qc[$];

    gfx_line_pixel_sink dut (
        .clk_i(clk_i), .rst_i(rst_i), .busy_i(busy_i), .valid_i(valid_i),
        .x_major_i(x_major_i), .major_i(major_i), .minor_i(minor_i),
        .read_pixel_o(read_pixel_o), .color_i(color_i),
        .target_width_i(target_width_i), .target_height_i(target_height_i),
        .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i),
        .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
        .write_o(write_o), .x_o(x_o), .y_o(y_o), .color_o(color_o),
        .ack_i(ack_i), .busy_o(busy_o), .done_o(done_o),
        .written_o(written_o), .discarded_o(discarded_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (write_o && ack_i) begin
            qx.push_back(int'(x_o));
            qy.push_back(int'(y_o));
            qc.push_back(color_o);
            last_ack = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_line(input logic [31:0] col);
        @(negedge clk_i);
        color_i = col;
        busy_i  = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic send(input int maj, input int mn);
        int t;
        @(negedge clk_i);
        major_i = 16'(maj);
        minor_i = 16'(mn);
        valid_i = 1'b1;
        #1;
        if (!read_pixel_o) begin
            stalls++;
            @(negedge clk_i);
            valid_i = 1'b0;
            t = 0;
            while (!read_pixel_o && t < 200) begin
                @(negedge clk_i);
                t++;
            end
            if (t >= 200) chk("read_timeout", 0, 1);
        end
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic end_and_wait(input string tag);
        int t;
        @(negedge clk_i);
        busy_i = 1'b0;
        t = 0;
        while (!done_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        chk({tag, "_done"}, 64'(done_o), 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 64'(qx.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size() && i < qx.size(); i++) begin
            chk($sformatf("%s_x%0d", tag, i), 64'(qx[i]), 64'(ex[i]));
            chk($sformatf("%s_y%0d", tag, i), 64'(qy[i]), 64'(ey[i]));
        end
        qx.delete(); qy.delete(); qc.delete();
        ex.delete(); ey.delete();
    endtask

    initial begin
        rst_i = 1'b1; busy_i = 1'b0; valid_i = 1'b0; x_major_i = 1'b1;
        major_i = '0; minor_i = '0; color_i = '0; ack_i = 1'b1;
        target_width_i = 16'd640; target_height_i = 16'd480;
        clip_x0_i = '0; clip_y0_i = '0; clip_x1_i = '0; clip_y1_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_write", 64'(write_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_read", 64'(read_pixel_o), 0);
        chk("rst_done", 64'(done_o), 0);
        chk("rst_written", 64'(written_o), 0);

        // horizontal line (0,5)..(3,5)
        start_line(32'hAABBCCDD);
        chk("h_busy", 64'(busy_o), 1);
        for (int i = 0; i < 4; i++) send(i, 5);
        end_and_wait("h");
        chk("h_color", 64'(qc.size() > 0 ? qc[0] : 32'h0), 64'hAABBCCDD);
        chk("h_done_lat", 64'(done_cyc - last_ack), 2);
        chk("h_written", 64'(written_o), 4);
        chk("h_discarded", 64'(discarded_o), 0);
        chk("h_busy_done", 64'(busy_o), 0);
        for (int i = 0; i < 4; i++) begin ex.push_back(i); ey.push_back(5); end
        check_writes("h");

        // y-major line
        x_major_i = 1'b0;
        start_line(32'h1);
        for (int i = 2; i <= 4; i++) send(i, 7);
        end_and_wait("ym");
        for (int i = 2; i <= 4; i++) begin ex.push_back(7); ey.push_back(i); end
        check_writes("ym");
        x_major_i = 1'b1;

        // backpressure: ack low, 10 pixels
        ack_i = 1'b0;
        start_line(32'h2);
        for (int i = 0; i < 4; i++) send(i, 1);
        @(negedge clk_i);
        major_i = 16'sd4; minor_i = 16'sd1; valid_i = 1'b1;
        #1 chk("bp_read_full", 64'(read_pixel_o), 0);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (20) @(negedge clk_i);
        chk("bp_read_held", 64'(read_pixel_o), 0);
        chk("bp_pending", 64'(dut.pending_q), 1);
        chk("bp_written", 64'(written_o), 4);
        chk("bp_head_x", 64'(x_o), 0);
        ack_i = 1'b1;
        #1 chk("bp_read_release", 64'(read_pixel_o), 1);
        @(posedge clk_i);
        #1;
        stalls = 0;
        for (int i = 5; i < 10; i++) send(i, 1);
        chk("bp_stalls", 64'(stalls), 0);
        end_and_wait("bp");
        chk("bp_written_all", 64'(written_o), 10);
        for (int i = 0; i < 10; i++) begin ex.push_back(i); ey.push_back(1); end
        check_writes("bp");

        // 8x8 target cull
        target_width_i = 16'd8; target_height_i = 16'd8;
        stalls = 0;
        start_line(32'h3);
        for (int i = 6; i <= 10; i++) send(i, 0);
        end_and_wait("cull");
        chk("cull_stalls", 64'(stalls), 0);
        chk("cull_written", 64'(written_o), 2);
        chk("cull_discarded", 64'(discarded_o), 3);
        for (int i = 6; i <= 7; i++) begin ex.push_back(i); ey.push_back(0); end
        check_writes("cull");
        target_width_i = 16'd640; target_height_i = 16'd480;

        // clip rectangle x in [2,4)
        clip_x0_i = 16'd2; clip_x1_i = 16'd4;
        clip_y0_i = 16'd0; clip_y1_i = 16'd100;
        start_line(32'h4);
        for (int i = 0; i <= 5; i++) send(i, 1);
        end_and_wait("clip");
`ifdef GFX_LINE_CLIP_EN
        chk("clip_written", 64'(written_o), 2);
        chk("clip_discarded", 64'(discarded_o), 4);
        for (int i = 2; i <= 3; i++) begin ex.push_back(i); ey.push_back(1); end
`else
        chk("clip_written", 64'(written_o), 6);
        chk("clip_discarded", 64'(discarded_o), 0);
        for (int i = 0; i <= 5; i++) begin ex.push_back(i); ey.push_back(1); end
`endif
        check_writes("clip");

        // reset mid-line with 3 queued
        ack_i = 1'b0;
        start_line(32'h5);
        for (int i = 0; i < 3; i++) send(i, 2);
        @(negedge clk_i);
        chk("mr_write_before", 64'(write_o), 1);
        begin
            int d0;
            d0 = done_cnt;
            rst_i = 1'b1;
            #1;
            chk("mr_write", 64'(write_o), 0);
            chk("mr_busy", 64'(busy_o), 0);
            repeat (2) @(negedge clk_i);
            rst_i = 1'b0; busy_i = 1'b0; ack_i = 1'b1;
            repeat (3) @(negedge clk_i);
            chk("mr_no_done", 64'(done_cnt), 64'(d0));
        end
        qx.delete(); qy.delete(); qc.delete();
        start_line(32'h6);
        for (int i = 0; i < 2; i++) send(i, 9);
        end_and_wait("mr");
        chk("mr_written", 64'(written_o), 2);
        for (int i = 0; i < 2; i++) begin ex.push_back(i); ey.push_back(9); end
        check_writes("mr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
